// File: rtl/freq_meter.sv
// Gate-window frequency meter: counts rising edges of sig_in over GATE_CYCLES clocks
// and latches the result as packed BCD digits with a saturation flag.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned DIGITS      = 8
) (
    input  logic                clk_50M,
    input  logic                reset,
    input  logic                sig_in,
    input  logic                meas_en,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                overflow,
    output logic                valid,
    output logic                busy
);
    localparam int unsigned CntW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(GATE_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GATE  = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    logic                s1_q, s2_q, prev_q;
    logic                edge_det;
    logic [1:0]          state_q, state_d;
    logic [CntW-1:0]     cnt_q;
    logic [4*DIGITS-1:0] acc_q, acc_inc;
    logic                ovf_q;
    logic                all_nines;

    assign edge_det = s2_q & ~prev_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (meas_en) state_d = GATE;
            GATE: begin
                if (!meas_en) state_d = IDLE;
                else if (cnt_q == CntLast) state_d = LATCH;
            end
            LATCH:   state_d = meas_en ? GATE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decimal ripple increment; all_nines ends up as the carry out of the top digit.
    always_comb begin
        acc_inc   = acc_q;
        all_nines = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (all_nines) begin
                if (acc_q[4*i +: 4] == 4'd9) begin
                    acc_inc[4*i +: 4] = 4'd0;
                end else begin
                    acc_inc[4*i +: 4] = acc_q[4*i +: 4] + 4'd1;
                    all_nines         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            prev_q   <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            s1_q    <= sig_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            busy    <= (state_d == GATE) || (state_d == LATCH);
            valid   <= 1'b0;
            unique case (state_q)
                GATE: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (edge_det) begin
                        if (all_nines) ovf_q <= 1'b1;
                        else           acc_q <= acc_inc;
                    end
                end
                LATCH: begin
                    bcd_out  <= acc_q;
                    overflow <= ovf_q;
                    valid    <= 1'b1;
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    ovf_q    <= 1'b0;
                end
                default: begin
                    cnt_q <= '0;
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench: two meters share random square-wave stimulus; expected counts come
// from the recorded input history over each window.
module tb_freq_meter;
    localparam int unsigned GA = 100;
    localparam int unsigned DA = 8;
    localparam int unsigned GB = 50;
    localparam int unsigned DB = 1;

    logic clk_50M = 1'b0;
    logic reset   = 1'b1;
    logic sig_in  = 1'b0;
    logic meas_en = 1'b0;

    logic [4*DA-1:0] bcd_a;
    logic            ovf_a, valid_a, busy_a;
    logic [4*DB-1:0] bcd_b;
    logic            ovf_b, valid_b, busy_b;

    freq_meter #(.GATE_CYCLES(GA), .DIGITS(DA)) dut_a (
        .clk_50M(clk_50M), .reset(reset), .sig_in(sig_in), .meas_en(meas_en),
        .bcd_out(bcd_a), .overflow(ovf_a), .valid(valid_a), .busy(busy_a)
    );

    freq_meter #(.GATE_CYCLES(GB), .DIGITS(DB)) dut_b (
        .clk_50M(clk_50M), .reset(reset), .sig_in(sig_in), .meas_en(meas_en),
        .bcd_out(bcd_b), .overflow(ovf_b), .valid(valid_b), .busy(busy_b)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct {
        int          edge_no;
        logic [31:0] bcd;
        logic        ovf;
    } exp_t;

    exp_t        qa[$], qb[$];
    int          pa[$], pb[$];
    logic        sig_h [0:32767];
    int          e = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] last_a = '0, last_b = '0;
    logic        lovf_a = 1'b0, lovf_b = 1'b0;
    logic        cur = 1'b0;
    int          run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, act, req);
        end
    endtask

    // Window whose last gate edge is g: count 0->1 transitions of the input history
    // as they emerge from the synchronizer, then saturate to the digit capacity.
    function automatic exp_t model(input int g, input int gc, input int dig);
        exp_t r;
        int   cnt = 0;
        int   maxv = 1;
        int   v;
        for (int n = g - gc + 1; n <= g; n++)
            if (sig_h[n-2] && !sig_h[n-3]) cnt++;
        for (int i = 0; i < dig; i++) maxv *= 10;
        maxv -= 1;
        r.ovf = (cnt > maxv);
        v = (cnt > maxv) ? maxv : cnt;
        r.bcd = '0;
        for (int i = 0; i < dig; i++) begin
            r.bcd[4*i +: 4] = 4'(v % 10);
            v /= 10;
        end
        r.edge_no = g + 1;
        return r;
    endfunction

    task automatic step(input logic r, input logic en, input int minr, input int maxr);
        @(negedge clk_50M);
        e++;
        if (maxr == 0) begin
            cur = 1'b0;
            run = 0;
        end else begin
            if (run == 0) begin
                cur = ~cur;
                run = $urandom_range(maxr, minr);
            end
            run--;
        end
        sig_in   = cur;
        sig_h[e] = cur;
        reset    = r;
        meas_en  = en;
        if (r) begin
            pa.delete(); pb.delete(); qa.delete(); qb.delete();
            last_a = '0; last_b = '0; lovf_a = 1'b0; lovf_b = 1'b0;
        end
        while (pa.size() > 0 && pa[0] == e) qa.push_back(model(pa.pop_front(), GA, DA));
        while (pb.size() > 0 && pb[0] == e) qb.push_back(model(pb.pop_front(), GB, DB));
    endtask

    // meas_en held for L edges starting at the next edge, then dropped.
    task automatic episode(input int len, input int minr, input int maxr);
        int m;
        m = e + 1;
        check("busy_idle_a", 32'(busy_a), 32'd0);
        check("busy_idle_b", 32'(busy_b), 32'd0);
        for (int j = 0; m + int'(GA) + j * int'(GA + 1) <= m + len - 1; j++)
            pa.push_back(m + int'(GA) + j * int'(GA + 1));
        for (int j = 0; m + int'(GB) + j * int'(GB + 1) <= m + len - 1; j++)
            pb.push_back(m + int'(GB) + j * int'(GB + 1));
        for (int k = 0; k < len; k++) begin
            step(1'b0, 1'b1, minr, maxr);
            if (k == 1) begin
                check("busy_run_a", 32'(busy_a), 32'd1);
                check("busy_run_b", 32'(busy_b), 32'd1);
            end
        end
        step(1'b0, 1'b0, minr, maxr);
        step(1'b0, 1'b0, minr, maxr);
        check("busy_drop_a", 32'(busy_a), 32'd0);
        check("busy_drop_b", 32'(busy_b), 32'd0);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk_50M);
            #1;
            if (valid_a) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected_valid at edge %0d: got valid=1, expected 0", e);
                end else begin
                    x = qa.pop_front();
                    check("a_valid_edge", 32'(e), 32'(x.edge_no));
                    check("a_bcd", bcd_a, x.bcd);
                    check("a_ovf", 32'(ovf_a), 32'(x.ovf));
                    last_a = x.bcd; lovf_a = x.ovf;
                end
            end else begin
                check("a_bcd_hold", bcd_a, last_a);
                check("a_ovf_hold", 32'(ovf_a), 32'(lovf_a));
            end
            if (valid_b) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected_valid at edge %0d: got valid=1, expected 0", e);
                end else begin
                    x = qb.pop_front();
                    check("b_valid_edge", 32'(e), 32'(x.edge_no));
                    check("b_bcd", 32'(bcd_b), x.bcd);
                    check("b_ovf", 32'(ovf_b), 32'(x.ovf));
                    last_b = x.bcd; lovf_b = x.ovf;
                end
            end else begin
                check("b_bcd_hold", 32'(bcd_b), last_b);
                check("b_ovf_hold", 32'(ovf_b), 32'(lovf_b));
            end
        end
    end

    initial begin
        sig_h[0] = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        check("reset_valid_a", 32'(valid_a), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 5, 5);

        // Period-10 input: one full window, then abort around gate cycle 50.
        episode(int'(GA) + 1 + 51, 5, 5);
        check("period10_a", bcd_a, 32'h0000_0010);
        check("period10_b", 32'(bcd_b), 32'h5);

        // Constant-low input over two windows.
        episode(2 * int'(GA + 1) + 3, 0, 0);
        check("const0_a", bcd_a, 32'h0);

        for (int i = 0; i < 14; i++) begin
            episode($urandom_range(330, 30), 2, $urandom_range(12, 2));
            for (int g = $urandom_range(4, 1); g > 0; g--) step(1'b0, 1'b0, 2, 8);
        end

        // Reset in the middle of a window.
        for (int k = 0; k < 50; k++) step(1'b0, 1'b1, 2, 6);
        step(1'b1, 1'b0, 2, 6);
        step(1'b0, 1'b0, 2, 6);
        check("midreset_busy_a", 32'(busy_a), 32'd0);
        check("midreset_valid_a", 32'(valid_a), 32'd0);
        check("midreset_busy_b", 32'(busy_b), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 2, 6);
        episode(int'(GA) + 10, 2, 3);

        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 2, 6);
        check("a_pending", 32'(qa.size()), 32'd0);
        check("b_pending", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
